// File: rtl/instr_loader_if.sv
// rtl/instr_loader_if.sv - byte stream, memory write port and status bundle for instr_loader
interface instr_loader_if;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_write_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_instr_in;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  err_code;

    modport master (
        output start, byte_in, byte_valid,
        input  byte_ready, mem_write_en, mem_addr, mem_instr_in, busy, done, error, err_code
    );

    modport slave (
        input  start, byte_in, byte_valid,
        output byte_ready, mem_write_en, mem_addr, mem_instr_in, busy, done, error, err_code
    );
endinterface

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - assembles a length-prefixed byte stream into 16-bit instr_memory writes
// Optional trailing XOR checksum byte enabled by defining CHECKSUM_EN.
module instr_loader #(
    parameter int MEM_DEPTH   = 181,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic          clk,
    input  logic          rst,
    instr_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CHK, S_DONE, S_ERR
    } state_t;

    state_t      r_state;
    logic        r_byte_ready;
    logic        r_write_en;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic [1:0]  r_err_code;
    logic [15:0] r_addr;
    logic [15:0] r_instr;
    logic [15:0] r_len;
    logic [15:0] r_widx;
    logic [15:0] r_tmo;
    logic [7:0]  r_hi;
`ifdef CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_accept;
    logic [15:0] w_len;

    assign w_accept = bus.byte_valid & r_byte_ready;
    assign w_len    = {r_len[15:8], bus.byte_in};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_byte_ready <= 1'b0;
            r_write_en   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= 2'b00;
            r_addr       <= '0;
            r_instr      <= '0;
            r_len        <= '0;
            r_widx       <= '0;
            r_tmo        <= '0;
            r_hi         <= '0;
`ifdef CHECKSUM_EN
            r_csum       <= '0;
`endif
        end else begin
            r_write_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.start) begin
                        r_state      <= S_LEN_HI;
                        r_byte_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_err_code   <= 2'b00;
                        r_tmo        <= '0;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_tmo <= '0;
`ifdef CHECKSUM_EN
                        r_csum <= r_csum ^ bus.byte_in;
`endif
                        case (r_state)
                            S_LEN_HI: begin
                                r_len[15:8] <= bus.byte_in;
`ifdef CHECKSUM_EN
                                r_csum      <= bus.byte_in;
`endif
                                r_state     <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                r_len  <= w_len;
                                r_widx <= '0;
                                if (w_len == 16'd0) begin
`ifdef CHECKSUM_EN
                                    r_state      <= S_CHK;
`else
                                    r_state      <= S_DONE;
                                    r_byte_ready <= 1'b0;
                                    r_busy       <= 1'b0;
                                    r_done       <= 1'b1;
`endif
                                end else if (w_len > 16'(MEM_DEPTH)) begin
                                    r_state      <= S_ERR;
                                    r_byte_ready <= 1'b0;
                                    r_busy       <= 1'b0;
                                    r_error      <= 1'b1;
                                    r_err_code   <= 2'b01;
                                end else begin
                                    r_state <= S_DATA_HI;
                                end
                            end
                            S_DATA_HI: begin
                                r_hi    <= bus.byte_in;
                                r_state <= S_DATA_LO;
                            end
                            S_DATA_LO: begin
                                r_write_en <= 1'b1;
                                r_addr     <= r_widx;
                                r_instr    <= {r_hi, bus.byte_in};
                                r_widx     <= r_widx + 16'd1;
                                if (r_widx == r_len - 16'd1) begin
`ifdef CHECKSUM_EN
                                    r_state      <= S_CHK;
`else
                                    r_state      <= S_DONE;
                                    r_byte_ready <= 1'b0;
                                    r_busy       <= 1'b0;
                                    r_done       <= 1'b1;
`endif
                                end else begin
                                    r_state <= S_DATA_HI;
                                end
                            end
`ifdef CHECKSUM_EN
                            S_CHK: begin
                                r_byte_ready <= 1'b0;
                                r_busy       <= 1'b0;
                                if (bus.byte_in == r_csum) begin
                                    r_state <= S_DONE;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state    <= S_ERR;
                                    r_error    <= 1'b1;
                                    r_err_code <= 2'b10;
                                end
                            end
`endif
                            default: ;
                        endcase
                    end else if (r_tmo == 16'(TIMEOUT_CYC - 1)) begin
                        // This idle cycle is the TIMEOUT_CYC-th since the last accepted byte
                        r_state      <= S_ERR;
                        r_byte_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        r_error      <= 1'b1;
                        r_err_code   <= 2'b11;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end
            endcase
        end
    end

    assign bus.byte_ready   = r_byte_ready;
    assign bus.mem_write_en = r_write_en;
    assign bus.mem_addr     = r_addr;
    assign bus.mem_instr_in = r_instr;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.err_code     = r_err_code;
endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized bench for instr_loader against a byte-count reference model
module tb_instr_loader;
    localparam int DEPTH   = 181;
    localparam int TIMEOUT = 65535;
`ifdef CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_loader_if bus();

    instr_loader #(.MEM_DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the load purely by count of accepted bytes
    bit          m_loading;
    int          m_nacc;
    int          m_len;
    int          m_idle;
    logic [7:0]  m_hi;
    logic [7:0]  m_csum;
    logic        m_done, m_error, m_we;
    logic [1:0]  m_code;
    logic [15:0] m_addr, m_data;

    logic [15:0] bmem [0:DEPTH-1];
    int          wcount = 0;

    task automatic model_reset();
        m_loading = 0; m_nacc = 0; m_len = 0; m_idle = 0; m_hi = 0; m_csum = 0;
        m_done = 0; m_error = 0; m_we = 0; m_code = 0; m_addr = 0; m_data = 0;
    endtask

    task automatic finish_load(input bit ok, input logic [1:0] code);
        m_loading = 0;
        m_done    = ok;
        m_error   = !ok;
        m_code    = code;
    endtask

    task automatic model_step();
        logic [7:0] b;
        m_we = 0;
        if (!m_loading) begin
            if (bus.start) begin
                m_loading = 1; m_nacc = 0; m_idle = 0; m_csum = 0; m_len = 0;
                m_done = 0; m_error = 0; m_code = 0;
            end
        end else if (bus.byte_valid) begin
            b = bus.byte_in;
            m_idle = 0;
            m_nacc++;
            if (CHK && m_nacc >= 3 && m_nacc == 2 * m_len + 3) begin
                if (b == m_csum) finish_load(1, 2'b00);
                else             finish_load(0, 2'b10);
            end else begin
                m_csum = m_csum ^ b;
                if (m_nacc == 1) m_hi = b;
                else if (m_nacc == 2) begin
                    m_len = int'({m_hi, b});
                    if (m_len > DEPTH)            finish_load(0, 2'b01);
                    else if (m_len == 0 && !CHK) finish_load(1, 2'b00);
                end else if (m_nacc % 2 == 1) m_hi = b;
                else begin
                    m_we   = 1;
                    m_addr = 16'((m_nacc - 4) / 2);
                    m_data = {m_hi, b};
                    if (m_nacc == 2 * m_len + 2 && !CHK) finish_load(1, 2'b00);
                end
            end
        end else begin
            m_idle++;
            if (m_idle == TIMEOUT) finish_load(0, 2'b11);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            model_reset();
        end else begin
            chk("byte_ready", 32'(bus.byte_ready), 32'(m_loading));
            chk("busy", 32'(bus.busy), 32'(m_loading));
            chk("done", 32'(bus.done), 32'(m_done));
            chk("error", 32'(bus.error), 32'(m_error));
            chk("err_code", 32'(bus.err_code), 32'(m_code));
            chk("write_en", 32'(bus.mem_write_en), 32'(m_we));
            chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
            chk("mem_instr_in", 32'(bus.mem_instr_in), 32'(m_data));
            if (bus.mem_write_en) begin
                wcount++;
                if (bus.mem_addr < 16'(DEPTH)) bmem[bus.mem_addr] = bus.mem_instr_in;
            end
            model_step();
        end
    end

    task automatic make_stream(input int n, input wq_t w, output bq_t q);
        logic [15:0] len;
        logic [7:0]  cs;
        len = 16'(n);
        q = {};
        q.push_back(len[15:8]);
        q.push_back(len[7:0]);
        foreach (w[i]) begin
            q.push_back(w[i][15:8]);
            q.push_back(w[i][7:0]);
        end
        cs = 8'h00;
        foreach (q[i]) cs = cs ^ q[i];
        if (CHK) q.push_back(cs);
    endtask

    // Called and returns at posedge+1
    task automatic feed(input bq_t q, input int gapmax, input bit swb);
        int ng;
        bus.start      = 1'b1;
        bus.byte_valid = swb;
        bus.byte_in    = (q.size() > 0) ? q[0] : 8'h00;
        @(posedge clk); #1;
        bus.start      = 1'b0;
        bus.byte_valid = 1'b0;
        for (int i = 0; i < q.size(); i++) begin
            ng = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            for (int g = 0; g < ng; g++) begin
                bus.byte_valid = 1'b0;
                bus.start      = bus.byte_ready && ($urandom_range(3, 0) == 0);
                @(posedge clk); #1;
            end
            bus.start      = 1'b0;
            bus.byte_valid = 1'b1;
            bus.byte_in    = q[i];
            @(negedge clk);
            if (!bus.byte_ready) break;
            @(posedge clk); #1;
        end
        bus.byte_valid = 1'b0;
        bus.start      = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bq_t  q;
        wq_t  w;
        int   w0;
        int   n;
        bit   hit;
        rst = 1'b1;
        bus.start = 1'b0; bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_busy", 32'(bus.busy), 0);
        chk("reset_ready", 32'(bus.byte_ready), 0);
        chk("reset_done", 32'(bus.done), 0);
        chk("reset_error", 32'(bus.error), 0);
        chk("reset_code", 32'(bus.err_code), 0);
        chk("reset_we", 32'(bus.mem_write_en), 0);
        chk("reset_addr", 32'(bus.mem_addr), 0);

        // Basic two-word load
        w = {}; w.push_back(16'h0004); w.push_back(16'h0101);
        make_stream(2, w, q);
        w0 = wcount;
        feed(q, 0, 1'b0);
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_busy", 32'(bus.busy), 0);
        chk("t1_writes", 32'(wcount - w0), 2);
        chk("t1_addr0", 32'(bmem[0]), 32'h0004);
        chk("t1_addr1", 32'(bmem[1]), 32'h0101);

        // Full-depth back-to-back load, then one word too many
        w = {};
        for (int i = 0; i < DEPTH; i++) w.push_back(16'(i * 257 + 16'h1234));
        make_stream(DEPTH, w, q);
        w0 = wcount;
        feed(q, 0, 1'b0);
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_writes", 32'(wcount - w0), 181);
        chk("t2_first", 32'(bmem[0]), 32'h1234);
        chk("t2_last", 32'(bmem[180]), 32'hC6E8);
        w = {}; w.push_back(16'hDEAD); w.push_back(16'hBEEF);
        make_stream(182, w, q);
        w0 = wcount;
        feed(q, 0, 1'b0);
        chk("t2_len_err", 32'(bus.error), 1);
        chk("t2_len_code", 32'(bus.err_code), 32'h1);
        chk("t2_len_nowrite", 32'(wcount - w0), 0);

        // Empty image, byte offered in the start cycle
        w = {};
        make_stream(0, w, q);
        w0 = wcount;
        feed(q, 0, 1'b1);
        chk("t3_done", 32'(bus.done), 1);
        chk("t3_nowrite", 32'(wcount - w0), 0);

        // Timeout after the third byte, then a clean restart
        w = {}; w.push_back(16'h0001); w.push_back(16'h0002);
        make_stream(2, w, q);
        q = q[0:2];
        feed(q, 0, 1'b0);
        for (int i = 0; i < TIMEOUT + 100 && !bus.error; i++) @(posedge clk);
        #1;
        chk("t4_error", 32'(bus.error), 1);
        chk("t4_code", 32'(bus.err_code), 32'h3);
        chk("t4_ready", 32'(bus.byte_ready), 0);
        w = {}; w.push_back(16'h0004); w.push_back(16'h0101);
        make_stream(2, w, q);
        feed(q, 2, 1'b0);
        chk("t4_restart_done", 32'(bus.done), 1);
        chk("t4_restart_code", 32'(bus.err_code), 0);

`ifdef CHECKSUM_EN
        q = {}; q.push_back(8'h00); q.push_back(8'h01); q.push_back(8'h00); q.push_back(8'h32);
        q.push_back(8'h33);
        feed(q, 0, 1'b0);
        chk("t5_good_done", 32'(bus.done), 1);
        q[4] = 8'h34;
        bmem[0] = 16'h0000;
        feed(q, 0, 1'b0);
        chk("t5_bad_code", 32'(bus.err_code), 32'h2);
        chk("t5_bad_addr0", 32'(bmem[0]), 32'h0032);
`endif

        // Random loads with gaps and ignored start pulses
        for (int t = 0; t < 12; t++) begin
            n = ($urandom_range(7, 0) == 0) ? int'($urandom_range(400, 182)) : int'($urandom_range(24, 0));
            w = {};
            for (int i = 0; i < ((n > 181) ? 3 : n); i++) w.push_back(16'($urandom));
            make_stream(n, w, q);
            if (CHK && n <= 181 && $urandom_range(3, 0) == 0) q[q.size() - 1] = ~q[q.size() - 1];
            feed(q, 3, 1'($urandom_range(1, 0)));
            chk("rand_finished", 32'(bus.busy), 0);
        end

        // Reset in the middle of a load while a write is on the port
        w = {};
        for (int i = 0; i < 6; i++) w.push_back(16'(16'hA000 + i));
        make_stream(6, w, q);
        @(posedge clk); #1 bus.start = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0;
        hit = 0;
        for (int i = 0; i < q.size(); i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_in    = q[i];
            @(posedge clk); #1;
            if (bus.mem_write_en && bus.mem_addr == 16'd2) begin
                hit = 1;
                break;
            end
        end
        bus.byte_valid = 1'b0;
        chk("t6_reached_word2", 32'(hit), 1);
        rst = 1'b1;
        #1;
        chk("t6_we_async", 32'(bus.mem_write_en), 0);
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_ready", 32'(bus.byte_ready), 0);
        chk("t6_addr", 32'(bus.mem_addr), 0);
        chk("t6_data", 32'(bus.mem_instr_in), 0);
        chk("t6_done", 32'(bus.done), 0);
        @(negedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        w = {}; w.push_back(16'h0004); w.push_back(16'h0101);
        make_stream(2, w, q);
        feed(q, 1, 1'b0);
        chk("t6_after_done", 32'(bus.done), 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
